hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/load_use_detect.sv | 21 ++
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } hz_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational detection of a load in EX feeding a source register read in ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  output logic                 load_use
);

  logic hit_rs1, hit_rs2;

  assign hit_rs1  = id_uses_rs1 & (id_rs1 == ex_rd);
  assign hit_rs2  = id_uses_rs2 & (id_rs2 == ex_rd);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign load_use = ex_mem_read & (ex_rd != REG_X0) & (hit_rs1 | hit_rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls with timeout, branch flushes,
// load-use bubbles and a saturating stall-cycle counter.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_branch_taken,
  input  logic                 mem_req,
  input  logic                 dmem_ready,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 id_ex_en,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 mem_wb_bubble,
  output logic                 mem_timeout,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam logic [7:0] MaxWaitC = 8'(MAX_WAIT);

  hz_state_e        state_q;
  logic [7:0]       wait_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             mem_timeout_q;
  logic             mem_stall;
  logic             load_use;

  assign mem_stall = mem_req & ~dmem_ready;

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (rst || state_q == TIMEOUT) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (mem_stall) begin
      // MEM_WB keeps loading, but with a bubble, so the stalled op is not written back twice
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      if (!pc_en && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        RUN: begin
          if (mem_stall) begin
            wait_cnt_q <= 8'd1;
            if (MaxWaitC == 8'd1) begin
              state_q       <= TIMEOUT;
              mem_timeout_q <= 1'b1;
            end else begin
              state_q <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          // a dropped mem_req leaves mem_stall low, so it releases like dmem_ready
          if (mem_stall) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
            if (wait_cnt_q + 8'd1 == MaxWaitC) begin
              state_q       <= TIMEOUT;
              mem_timeout_q <= 1'b1;
            end
          end else begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end
        end
        TIMEOUT: ;
        default: state_q <= RUN;
      endcase
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
